fifo_rd_stream: RTL and testbench
=================================

# fifo_rd_stream

Downstream drain stage for the synchronous FIFO. It issues read requests into the FIFO's read port and absorbs the FIFO's one-cycle sequential read latency in a 2-entry output buffer. It presents the words in order on a valid/ready stream toward the consumer. It also keeps a transferred-word counter and a sticky underflow error, so the environment can check that reads are never issued into an empty FIFO.

## Interface
- FIFO_WIDTH, 16, width of FIFO data and of the output stream word
- CNT_WIDTH, 16, width of the transferred-word counter

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- enable  in  1  allows new FIFO reads while high
- clr  in  1  synchronous clear of word_cnt and underflow_err
- fifo_data_out  in  FIFO_WIDTH  FIFO read data, valid the cycle after an accepted rd_en
- fifo_empty  in  1  FIFO empty flag (combinational)
- fifo_underflow  in  1  FIFO underflow (sequential, asserted the cycle after a rejected read)
- fifo_rd_en  out  1  FIFO read enable (combinational)
- m_data  out  FIFO_WIDTH  output stream word (registered, buffer head)
- m_valid  out  1  m_data holds a valid word
- m_ready  in  1  consumer accepts m_data this cycle
- busy  out  1  state != IDLE
- word_cnt  out  CNT_WIDTH  words accepted by the consumer, saturating
- underflow_err  out  1  sticky: FIFO reported underflow on a read this block issued

## Operation
- Internal state:
  - occ: buffer occupancy, 0..2
  - inflight: 1 when a read was issued last cycle
  - pop = m_valid & m_ready
- Read issue: fifo_rd_en = (state == RUN) & !fifo_empty & ((occ + inflight - pop) < 2). This is a credit check that allows full throughput at steady state. The m_ready → fifo_rd_en path is combinational.
- Capture: on an edge with inflight = 1:
  - if fifo_underflow = 0, push fifo_data_out at the buffer tail;
  - if fifo_underflow = 1, drop the word and set underflow_err.
- Push and pop in the same cycle are legal in any occupancy. Occupancy never exceeds 2 by construction; exceeding it is a design error, covered by an assertion.
- Ordering: the output order equals the FIFO read order. No word is duplicated or skipped.
- FSM:
  - IDLE → RUN when enable = 1.
  - RUN → DRAIN when enable = 0. No new reads are issued from then on.
  - DRAIN → IDLE when occ = 0 and inflight = 0.
  - DRAIN → RUN when enable = 1 again.
- word_cnt increments on pop and saturates at 2^CNT_WIDTH-1.
- clr zeroes word_cnt and underflow_err. clr wins over a simultaneous pop or underflow.
- m_valid = (occ != 0). m_data is stable while m_valid = 1 and m_ready = 0.

## Timing
- Reset values:
  - fifo_rd_en = 0 (gated by rst as well as by state)
  - m_valid = 0, m_data = 0
  - busy = 0, word_cnt = 0, underflow_err = 0
  - occ = 0, inflight = 0, state = IDLE
- Latency: rd_en high in cycle N → FIFO data on fifo_data_out in N+1 → captured at the end of N+1 → m_valid = 1 in cycle N+2 (when the buffer was empty).
- Throughput: 1 word/cycle with m_ready held high and the FIFO non-empty.
- Backpressure: when m_ready is low, at most 2 words are buffered. The in-flight read is counted in the credit, so the buffer is never overrun.
- Reset mid-operation: the buffer and any in-flight word are discarded. That word has already left the FIFO and is lost, which is accepted behaviour.
- fifo_empty rising in the same cycle as a credit: no read is issued.
- enable falling with a read in flight: that word is still captured and delivered during DRAIN.

## Test plan
- FIFO preloaded with 0x0001..0x0008, enable = 1, m_ready = 1 → rd_en high 8 consecutive cycles; first m_valid 2 cycles after the first rd_en; words 0x0001..0x0008 delivered on 8 consecutive cycles; word_cnt = 8.
- 8 words preloaded, m_ready = 0 for 10 cycles → exactly 2 reads issued; m_data = 0x0001 held stable. Release m_ready → remaining words delivered in order; word_cnt = 8.
- enable dropped one cycle after the first rd_en (4 words in FIFO) → state DRAIN; in-flight word delivered; busy falls once the buffer is empty; 2 words remain in the FIFO.
- Force fifo_underflow = 1 the cycle after a read → word dropped, m_valid stays 0, underflow_err = 1 and stays set. Assert clr → underflow_err = 0 and word_cnt = 0.
- CNT_WIDTH = 4, 20 words streamed → word_cnt saturates at 15.
- rst pulsed while occ = 2 and a read is in flight → all outputs at reset values immediately (asynchronous). After release with enable = 1, reads resume with the next FIFO word.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// Drain stage for the synchronous FIFO: credit-based read issue, 2-entry output
// buffer absorbing the FIFO read latency, valid/ready output, counter and sticky error.
module fifo_rd_stream #(
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  clr,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    output logic                  fifo_rd_en,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  word_cnt,
    output logic                  underflow_err
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t                state, state_nxt;
    logic [1:0]            occ, occ_nxt;
    logic                  inflight;
    logic [FIFO_WIDTH-1:0] buf1, head_nxt, buf1_nxt;
    logic                  pop, push, credit;

    assign pop     = m_valid & m_ready;
    assign push    = inflight & ~fifo_underflow;
    assign m_valid = (occ != 2'd0);
    assign busy    = (state != IDLE);

    // occ + inflight - pop < 2, rearranged so the sum never goes negative
    assign credit     = ({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
    assign fifo_rd_en = ~rst & (state == RUN) & ~fifo_empty & credit;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = RUN;
            RUN:     if (!enable) state_nxt = DRAIN;
            DRAIN: begin
                if (enable)
                    state_nxt = RUN;
                else if (occ == 2'd0 && !inflight)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // m_data is the buffer head; buf1 is the second slot
    always_comb begin
        head_nxt = m_data;
        buf1_nxt = buf1;
        occ_nxt  = occ;
        case (occ)
            2'd0: begin
                if (push) begin
                    head_nxt = fifo_data_out;
                    occ_nxt  = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_nxt = fifo_data_out;
                end else if (push) begin
                    buf1_nxt = fifo_data_out;
                    occ_nxt  = 2'd2;
                end else if (pop) begin
                    occ_nxt = 2'd0;
                end
            end
            default: begin
                if (pop) begin
                    head_nxt = buf1;
                    if (push)
                        buf1_nxt = fifo_data_out;
                    else
                        occ_nxt = 2'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            occ           <= 2'd0;
            inflight      <= 1'b0;
            m_data        <= '0;
            buf1          <= '0;
            word_cnt      <= '0;
            underflow_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            occ      <= occ_nxt;
            inflight <= fifo_rd_en;
            m_data   <= head_nxt;
            buf1     <= buf1_nxt;
            if (clr) begin
                word_cnt      <= '0;
                underflow_err <= 1'b0;
            end else begin
                if (pop && word_cnt != '1)
                    word_cnt <= word_cnt + 1'b1;
                if (inflight && fifo_underflow)
                    underflow_err <= 1'b1;
            end
        end
    end

    a_no_overrun: assert property (@(posedge clk) disable iff (rst)
        !(occ == 2'd2 && push && !pop));
    a_occ_range: assert property (@(posedge clk) disable iff (rst)
        occ != 2'd3);

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream: a queue-based FIFO model feeds the DUT,
// serviced reads push expected words, a negedge monitor checks the output stream.
module tb_fifo_rd_stream;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic         clr;
    logic [W-1:0] fifo_data_out;
    logic         fifo_empty;
    logic         fifo_underflow;
    logic         m_ready;
    logic         fifo_rd_en;
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         busy;
    logic [15:0]  word_cnt;
    logic         underflow_err;
    logic         rd_en4;
    logic [W-1:0] m_data4;
    logic         m_valid4;
    logic         busy4;
    logic [3:0]   word_cnt4;
    logic         uerr4;

    always #5 clk = ~clk;

    fifo_rd_stream #(.FIFO_WIDTH(W), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .clr(clr),
        .fifo_data_out(fifo_data_out), .fifo_empty(fifo_empty),
        .fifo_underflow(fifo_underflow), .fifo_rd_en(fifo_rd_en),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .busy(busy), .word_cnt(word_cnt), .underflow_err(underflow_err)
    );

    // Narrow-counter twin sharing every input; identical stream behaviour keeps the shared FIFO model valid
    fifo_rd_stream #(.FIFO_WIDTH(W), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .enable(enable), .clr(clr),
        .fifo_data_out(fifo_data_out), .fifo_empty(fifo_empty),
        .fifo_underflow(fifo_underflow), .fifo_rd_en(rd_en4),
        .m_data(m_data4), .m_valid(m_valid4), .m_ready(m_ready),
        .busy(busy4), .word_cnt(word_cnt4), .underflow_err(uerr4)
    );

    int checks = 0;
    int failures = 0;
    logic [W-1:0] fifo_q[$];
    logic [W-1:0] exp_q[$];
    bit rd_s = 1'b0;
    bit force_uf = 1'b0;
    int cyc = 0;
    int n_rd, first_rd, last_rd, first_val, n_del, first_del, last_del;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic clear_stats();
        n_rd = 0; first_rd = -1; last_rd = -1; first_val = -1;
        n_del = 0; first_del = -1; last_del = -1;
    endtask

    task automatic preload(input int n, input logic [W-1:0] base);
        logic [W-1:0] v;
        v = base;
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(v);
            v = v + 1'b1;
        end
    endtask

    // One clock: FIFO model answers the read sampled before the edge, then new inputs, then sampling
    task automatic step(input bit en, input bit rdy, input bit cl);
        @(posedge clk);
        #1;
        fifo_underflow = 1'b0;
        if (rd_s) begin
            checks++;
            if (fifo_q.size() == 0) begin
                failures++;
                $display("FAIL rd_on_empty: fifo_rd_en=1 required 0 while empty (cycle %0d)", cyc);
                fifo_underflow = 1'b1;
            end else begin
                fifo_data_out = fifo_q.pop_front();
                if (force_uf) begin
                    fifo_underflow = 1'b1;
                    force_uf = 1'b0;
                end else begin
                    exp_q.push_back(fifo_data_out);
                end
            end
        end
        fifo_empty = (fifo_q.size() == 0);
        enable  = en;
        m_ready = rdy;
        clr     = cl;
        #1;
        rd_s = fifo_rd_en;
        cyc++;
        if (rd_s) begin
            n_rd++;
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
        end
        if (m_valid && first_val < 0) first_val = cyc;
        if (m_valid && m_ready) begin
            n_del++;
            if (first_del < 0) first_del = cyc;
            last_del = cyc;
        end
    endtask

    task automatic drain_to_idle();
        int k;
        k = 0;
        while ((busy || exp_q.size() != 0) && k < 30) begin
            step(1'b0, 1'b1, 1'b0);
            k++;
        end
        checks++;
        if (busy || exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: busy=%0d pending=%0d required busy=0 pending=0",
                     busy, exp_q.size());
        end
    endtask

    task automatic flush();
        int k;
        k = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0 || m_valid) && k < 300) begin
            step(1'b1, 1'b1, 1'b0);
            k++;
        end
        checks++;
        if (fifo_q.size() != 0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL flush_timeout: fifo=%0d pending=%0d required 0 and 0",
                     fifo_q.size(), exp_q.size());
        end
        drain_to_idle();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_rd_en"}, 32'(fifo_rd_en), 32'd0);
        chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        chk({tag, "_m_data"}, 32'(m_data), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_word_cnt"}, 32'(word_cnt), 32'd0);
        chk({tag, "_underflow_err"}, 32'(underflow_err), 32'd0);
    endtask

    // Monitor: stream order, stall stability, counters and sticky error
    initial begin : monitor
        int exp_cnt, exp_cnt4;
        bit exp_err, prev_hold, popped;
        logic [W-1:0] prev_data, e;
        exp_cnt = 0; exp_cnt4 = 0; exp_err = 1'b0; prev_hold = 1'b0; prev_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                exp_cnt = 0; exp_cnt4 = 0; exp_err = 1'b0; prev_hold = 1'b0;
                continue;
            end
            chk("word_cnt", 32'(word_cnt), 32'(exp_cnt));
            chk("word_cnt4", 32'(word_cnt4), 32'(exp_cnt4));
            chk("underflow_err", 32'(underflow_err), 32'(exp_err));
            chk("underflow_err4", 32'(uerr4), 32'(exp_err));
            chk("twin_stream", {13'd0, rd_en4, m_valid4, busy4, m_data4},
                {13'd0, fifo_rd_en, m_valid, busy, m_data});
            checks++;
            if (exp_q.size() > 2) begin
                failures++;
                $display("FAIL outstanding: %0d words held required at most 2", exp_q.size());
            end
            if (prev_hold) begin
                chk("stall_valid", 32'(m_valid), 32'd1);
                chk("stall_data", 32'(m_data), 32'(prev_data));
            end
            popped = m_valid && m_ready;
            if (popped) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL spurious_word: m_data=0x%0h delivered, required no word", m_data);
                end else begin
                    e = exp_q.pop_front();
                    checks--;
                    chk("stream_data", 32'(m_data), 32'(e));
                end
            end
            if (clr) begin
                exp_cnt = 0; exp_cnt4 = 0; exp_err = 1'b0;
            end else begin
                if (popped && exp_cnt < 65535) exp_cnt++;
                if (popped && exp_cnt4 < 15) exp_cnt4++;
                if (fifo_underflow) exp_err = 1'b1;
            end
            prev_hold = m_valid && !m_ready;
            prev_data = m_data;
        end
    end

    initial begin : driver
        rst = 1'b1; enable = 1'b0; clr = 1'b0; m_ready = 1'b0;
        fifo_data_out = '0; fifo_empty = 1'b1; fifo_underflow = 1'b0;
        clear_stats();
        #1;
        check_reset_values("init");
        @(posedge clk); @(posedge clk); #3;
        rst = 1'b0;

        // Full-throughput burst of 8 words
        preload(8, 16'h0001);
        clear_stats();
        for (int i = 0; i < 14; i++) step(1'b1, 1'b1, 1'b0);
        chk("t1_reads", 32'(n_rd), 32'd8);
        chk("t1_rd_span", 32'(last_rd - first_rd), 32'd7);
        chk("t1_latency", 32'(first_val - first_rd), 32'd2);
        chk("t1_deliveries", 32'(n_del), 32'd8);
        chk("t1_del_span", 32'(last_del - first_del), 32'd7);
        chk("t1_word_cnt", 32'(word_cnt), 32'd8);
        drain_to_idle();
        step(1'b0, 1'b1, 1'b1);

        // Backpressure: only two reads while stalled, head held
        preload(8, 16'h0001);
        clear_stats();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
        chk("t2_reads_stalled", 32'(n_rd), 32'd2);
        chk("t2_head_valid", 32'(m_valid), 32'd1);
        chk("t2_head_data", 32'(m_data), 32'h0001);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0);
        chk("t2_word_cnt", 32'(word_cnt), 32'd8);
        chk("t2_fifo_left", 32'(fifo_q.size()), 32'd0);
        drain_to_idle();

        // Enable dropped one cycle after the first read
        preload(4, 16'h0011);
        clear_stats();
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("t3_drain_busy", 32'(busy), 32'd1);
        chk("t3_drain_no_rd", 32'(rd_s), 32'd0);
        drain_to_idle();
        chk("t3_idle_no_valid", 32'(m_valid), 32'd0);
        chk("t3_reads", 32'(n_rd), 32'd2);
        chk("t3_fifo_left", 32'(fifo_q.size()), 32'd2);
        flush();

        // Forced underflow on the only read
        force_uf = 1'b1;
        preload(1, 16'h00AA);
        clear_stats();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0);
        chk("t4_reads", 32'(n_rd), 32'd1);
        chk("t4_never_valid", 32'(first_val), 32'hFFFF_FFFF);
        chk("t4_err_set", 32'(underflow_err), 32'd1);
        chk("t4_cnt_kept", 32'(word_cnt), 32'd12);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        chk("t4_clr_err", 32'(underflow_err), 32'd0);
        chk("t4_clr_cnt", 32'(word_cnt), 32'd0);
        drain_to_idle();

        // 20 words: 16-bit counter counts them, 4-bit counter saturates
        preload(20, 16'h0100);
        clear_stats();
        for (int i = 0; i < 30; i++) step(1'b1, 1'b1, 1'b0);
        chk("t5_word_cnt", 32'(word_cnt), 32'd20);
        chk("t5_word_cnt4_sat", 32'(word_cnt4), 32'd15);
        chk("t5_del_span", 32'(last_del - first_del), 32'd19);
        drain_to_idle();

        // Asynchronous reset with a word buffered and a read in flight
        step(1'b0, 1'b1, 1'b1);
        preload(8, 16'h0001);
        clear_stats();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
        chk("t6_pre_valid", 32'(m_valid), 32'd1);
        chk("t6_pre_rd", 32'(rd_s), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check_reset_values("t6_async");
        rd_s = 1'b0;
        fifo_underflow = 1'b0;
        @(posedge clk); @(posedge clk); #3;
        rst = 1'b0;
        clear_stats();
        begin
            int k;
            k = 0;
            while (!m_valid && k < 10) begin
                step(1'b1, 1'b1, 1'b0);
                k++;
            end
        end
        chk("t6_resume_valid", 32'(m_valid), 32'd1);
        chk("t6_resume_word", 32'(m_data), 32'h0003);
        flush();

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0 && fifo_q.size() < 12) begin
                int n;
                n = $urandom_range(1, 3);
                for (int j = 0; j < n; j++) fifo_q.push_back(W'($urandom));
            end
            if ($urandom_range(0, 39) == 0) force_uf = 1'b1;
            step($urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 59) == 0);
        end
        force_uf = 1'b0;
        flush();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
